// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared control-bit indices, occupancy encoding and default widths for pipeline stages
package mips_pipe_pkg;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W = 5;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry elastic buffer (main + skid register) with synchronous flush
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  occ_e state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic accept, emit;
  assign in_ready = state_q != OCC_TWO;
  assign out_valid = state_q != OCC_EMPTY;
  assign out_data = main_q;
  assign accept = in_valid & in_ready;
  assign emit = out_valid & out_ready;
  always_comb begin
    state_d = flush ? OCC_EMPTY :
              state_q == OCC_EMPTY ? (accept ? OCC_ONE : OCC_EMPTY) :
              state_q == OCC_ONE ? (accept & !emit ? OCC_TWO : emit & !accept ? OCC_EMPTY : OCC_ONE) :
              (emit ? OCC_ONE : OCC_TWO);
    main_d = state_q == OCC_TWO ? (emit ? skid_q : main_q) :
             accept & (!out_valid | emit) ? in_data : main_q;
    skid_d = state_q == OCC_ONE & accept & !emit ? in_data : skid_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: elastic MEM->WB register with bubble-gated control, write-back mux and stall counter
module mem_wb_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W = DEF_RD_W,
  parameter int CTRL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_rdata,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int PW = CTRL_W + 2 * DATA_W + RD_W;
  logic [PW-1:0] out_pay;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CNT_W-1:0] stall_q, stall_d;
  pipe_skid_buf #(.W(PW)) u_buf (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data({in_ctrl, in_alu, in_rdata, in_rd}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_pay)
  );
  assign {main_ctrl, out_alu, out_rdata, out_rd} = out_pay;
  // stale payload may linger after flush, so control is masked by valid
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
  assign out_wb_data = out_ctrl[CTRL_MEMTOREG] ? out_rdata : out_alu;
  assign stall_cnt = stall_q;
  always_comb stall_d = stall_q + CNT_W'(out_valid & ~out_ready & ~&stall_q);
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb_mem_wb_pipe_stage: directed plus random stimulus checked against a queue-based FIFO model
module tb_mem_wb_pipe_stage;
  typedef struct {
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] r;
    logic [4:0]  d;
  } beat_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [1:0] in_ctrl = 0;
  logic [31:0] in_alu = 0, in_rdata = 0;
  logic [4:0] in_rd = 0;
  logic in_ready, out_valid, s_in_ready, s_out_valid;
  logic [1:0] out_ctrl, s_out_ctrl;
  logic [31:0] out_alu, out_rdata, out_wb_data, s_out_alu, s_out_rdata, s_out_wb_data;
  logic [4:0] out_rd, s_out_rd;
  logic [15:0] stall_cnt;
  logic [1:0] s_stall_cnt;
  beat_t q[$];
  int unsigned cnt_m = 0, sat_m = 0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_wb_pipe_stage u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_rdata(in_rdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_alu(out_alu),
    .out_rdata(out_rdata), .out_rd(out_rd), .out_wb_data(out_wb_data), .stall_cnt(stall_cnt)
  );
  mem_wb_pipe_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_rdata(in_rdata), .in_rd(in_rd),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_alu(s_out_alu),
    .out_rdata(s_out_rdata), .out_rd(s_out_rd), .out_wb_data(s_out_wb_data), .stall_cnt(s_stall_cnt)
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
    chk("sat_cnt", 64'(s_stall_cnt), 64'(sat_m));
    chk("sat_in_ready", 64'(s_in_ready), 64'(q.size() < 2));
    if (q.size() == 0) begin
      chk("out_ctrl_bubble", 64'(out_ctrl), 64'(0));
      chk("sat_ctrl_bubble", 64'(s_out_ctrl), 64'(0));
    end else begin
      chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
      chk("out_alu", 64'(out_alu), 64'(q[0].a));
      chk("out_rdata", 64'(out_rdata), 64'(q[0].r));
      chk("out_rd", 64'(out_rd), 64'(q[0].d));
      chk("out_wb_data", 64'(out_wb_data), 64'(q[0].c[1] ? q[0].r : q[0].a));
      chk("sat_wb_data", 64'(s_out_wb_data), 64'(q[0].c[1] ? q[0].r : q[0].a));
    end
  endtask
  task automatic step(bit v, logic [1:0] c, logic [31:0] a, logic [31:0] r, logic [4:0] d, bit ordy, bit fl);
    bit acc, emi;
    in_valid = v; in_ctrl = c; in_alu = a; in_rdata = r; in_rd = d; out_ready = ordy; flush = fl;
    acc = v && q.size() < 2;
    emi = q.size() > 0 && ordy;
    @(posedge clk);
    if (q.size() > 0 && !ordy) begin
      if (cnt_m < 65535) cnt_m++;
      if (sat_m < 3) sat_m++;
    end
    if (fl) q.delete();
    else begin
      if (emi) void'(q.pop_front());
      if (acc) q.push_back('{c, a, r, d});
    end
    #1 check_all();
  endtask
  task automatic idle(bit ordy);
    step(0, 2'($urandom), $urandom, $urandom, 5'($urandom), ordy, 0);
  endtask
  initial begin
    #11 check_all();
    reset = 0;
    step(1, 2'b01, 32'h1234, 32'h0, 5'd7, 1, 0);
    chk("first_wb", 64'(out_wb_data), 64'h1234);
    idle(1);
    step(1, 2'b01, 32'hA, 32'h0, 5'd1, 0, 0);
    step(1, 2'b01, 32'hB, 32'h0, 5'd2, 0, 0);
    idle(0);
    idle(0);
    chk("bp_stall3", 64'(stall_cnt), 64'd3);
    idle(1);
    idle(1);
    idle(1);
    for (int i = 0; i < 8; i++) step(1, 2'b01, 32'(i), $urandom, 5'(i), 1, 0);
    idle(1);
    step(1, 2'b11, 32'h100, 32'hDEADBEEF, 5'd9, 1, 0);
    chk("load_wb", 64'(out_wb_data), 64'hDEADBEEF);
    idle(1);
    step(1, 2'b11, 32'h1, 32'h2, 5'd3, 0, 0);
    step(1, 2'b01, 32'h3, 32'h4, 5'd4, 0, 0);
    step(1, 2'b11, 32'h55, 32'h66, 5'd5, 0, 1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    idle(1);
    idle(1);
    step(1, 2'b11, 32'h77, 32'h88, 5'd6, 0, 0);
    for (int i = 0; i < 5; i++) idle(0);
    #3 reset = 1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_sat_cnt", 64'(s_stall_cnt), 64'd0);
    q.delete();
    cnt_m = 0;
    sat_m = 0;
    #1 reset = 0;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom, 5'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
